alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-to-execute pipeline register placed directly upstream of the ALU. It accepts one raw RV32I instruction per handshake together with its PC and register-file operands. It generates the immediate, selects ALU operands and the 4-bit ALU function select, and holds the result in a registered slot that drives the ALU's A, B and FS inputs. It supports back-pressure from execute and a flush from branch resolution.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  32  instruction address.
- `in_rs1_data`, `in_rs2_data`  in  32 each  register-file read data.
- `flush`  in  1  kill the held and incoming instruction.
- `out_valid`  out  1  slot holds a live instruction.
- `out_ready`  in  1  execute consumes the slot this cycle.
- `alu_a`, `alu_b`  out  32 each  ALU operands.
- `alu_fs`  out  4  ALU function select.
- `out_rd`  out  5  destination register index.
- `out_we`  out  1  writeback enable; forced 0 when `out_rd` = 0.
- `out_branch`  out  1  conditional branch; the ALU result is the condition.
- `out_br_inv`  out  1  invert the ALU condition for BNE/BGE/BGEU.
- `out_rs2_data`  out  32  store data passthrough.
- `out_illegal`  out  1  unrecognised opcode or funct.

## Operation
- FS codes: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 pass A, 9 pass B, 12 SLT, 13 SLTU, 14 EQ.
- Immediate formats are I, S, B, U and J, each sign-extended from instr[31]. Shift-immediate B = {27'd0, instr[24:20]}.
- OP (0110011):
  - A = rs1, B = rs2.
  - funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - instr[30] = 1 with funct3 000 gives SUB; with funct3 101 gives SRA.
  - instr[30] = 1 with any other funct3 is illegal. funct7 other than 0000000 or 0100000 is illegal.
- OP-IMM (0010011): A = rs1, B = I-imm (shift-immediate for funct3 001/101). SRAI when instr[30] = 1; SUB is never generated.
- LUI: A = 0, B = U-imm, FS 9.
- AUIPC: A = pc, B = U-imm, FS 3.
- JAL and JALR: A = pc, B = 4, FS 3, we = 1. The target is computed elsewhere.
- BRANCH (1100011):
  - A = rs1, B = rs2, branch = 1, we = 0.
  - BEQ/BNE use FS 14, BLT/BGE use FS 12, BLTU/BGEU use FS 13.
  - br_inv = funct3[0]. funct3 010 or 011 is illegal.
- LOAD: A = rs1, B = I-imm, FS 3. STORE: A = rs1, B = S-imm, FS 3, we = 0.
- Any other opcode: illegal = 1, we = 0, branch = 0, A = B = 0, FS 3.
- Slot register:
  - `in_ready` = !out_valid | out_ready | flush.
  - Load occurs when in_valid & in_ready & !flush.
  - Otherwise out_valid clears when out_ready or flush is asserted.
  - All payload fields hold their value while the slot is stalled.
- When out_valid = 0, `out_we`, `out_branch` and `out_illegal` read as 0. Payload fields are don't-care.

## Timing
- Latency is one cycle: an instruction accepted at edge N drives the ALU from after edge N until it is consumed.
- Full throughput: a simultaneous consume and accept in the same cycle refills the slot with no bubble.
- `flush` has priority over all other inputs. The slot is empty the next cycle and the coincident `in_valid` is dropped.
- Reset state: out_valid = 0, alu_a = alu_b = 0, alu_fs = 3, out_rd = 0, and all flags 0.
- Reset asserted mid-stall discards the held instruction.

## Test plan
- ADDI x5, x1, -1 with rs1 = 0x10 and out_ready = 1: the next cycle gives alu_a = 0x10, alu_b = 0xFFFFFFFF, fs = 3, rd = 5, we = 1.
- SRAI x3, x3, 4 (0x4041D193): alu_b = 0x00000004, fs = 2. SUB x1, x2, x3: fs = 4.
- BGEU: fs = 13, branch = 1, br_inv = 1, we = 0. LUI x7, 0x12345: a = 0, b = 0x12345000, fs = 9.
- Stall: hold out_ready = 0 for 3 cycles. in_ready must stay 0 and outputs must be stable. A new instruction offered during the stall is accepted only in the cycle out_ready returns, with no bubble.
- Flush asserted with in_valid = 1 and the slot full: the next cycle out_valid = 0 and the incoming instruction is never presented.
- Opcode 0x7F, and OP with funct7 0x01: illegal = 1, we = 0. Also instr with rd = 0: we = 0. Reset during a stall: out_valid = 0 the next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//
// Decode-to-execute pipeline register that sits directly in front of the ALU.
// Each handshake takes one raw RV32I instruction, its PC and its register-file
// operands. The stage builds the immediate, picks the ALU operands and the
// 4-bit function select, and holds the result in a single registered slot.
// That slot drives the ALU A/B/FS inputs until execute consumes it.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready decode handshake
//   in_instr, in_pc   raw instruction word and its address
//   in_rs1_data,
//   in_rs2_data       register-file read data
//   flush             kills the held and the incoming instruction
//   out_valid/out_ready  execute handshake
//   alu_a, alu_b      ALU operands
//   alu_fs            ALU function select
//   out_rd            destination register index
//   out_we            writeback enable (never set for x0)
//   out_branch        conditional branch; the ALU result is the condition
//   out_br_inv        invert the ALU condition (BNE/BGE/BGEU)
//   out_rs2_data      store data passthrough
//   out_illegal       unrecognised opcode or funct field

module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_fs,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_branch,
  output logic            out_br_inv,
  output logic [XLEN-1:0] out_rs2_data,
  output logic            out_illegal
);

  // ALU function select encodings
  localparam logic [3:0] FS_SLL  = 4'd0;
  localparam logic [3:0] FS_SRL  = 4'd1;
  localparam logic [3:0] FS_SRA  = 4'd2;
  localparam logic [3:0] FS_ADD  = 4'd3;
  localparam logic [3:0] FS_SUB  = 4'd4;
  localparam logic [3:0] FS_AND  = 4'd5;
  localparam logic [3:0] FS_OR   = 4'd6;
  localparam logic [3:0] FS_XOR  = 4'd7;
  localparam logic [3:0] FS_PASB = 4'd9;
  localparam logic [3:0] FS_SLT  = 4'd12;
  localparam logic [3:0] FS_SLTU = 4'd13;
  localparam logic [3:0] FS_EQ   = 4'd14;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] sh_imm;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Only the immediate formats that become an ALU operand are built here;
  // branch and jump targets are computed by a separate adder downstream.
  assign i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign u_imm  = {in_instr[31:12], 12'd0};
  assign sh_imm = {27'd0, in_instr[24:20]};

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_fs;
  logic            dec_we;
  logic            dec_branch;
  logic            dec_br_inv;
  logic            dec_illegal;

  // Instruction decode. Each opcode sets its operands and function; a final
  // override collapses every illegal encoding to the same inert form
  // (A = B = 0, ADD, no writeback, no branch).
  always_comb begin
    dec_a       = '0;
    dec_b       = '0;
    dec_fs      = FS_ADD;
    dec_we      = 1'b0;
    dec_branch  = 1'b0;
    dec_br_inv  = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_a  = in_rs1_data;
        dec_b  = in_rs2_data;
        dec_we = 1'b1;
        case (funct3)
          3'b000:  dec_fs = in_instr[30] ? FS_SUB : FS_ADD;
          3'b001:  dec_fs = FS_SLL;
          3'b010:  dec_fs = FS_SLT;
          3'b011:  dec_fs = FS_SLTU;
          3'b100:  dec_fs = FS_XOR;
          3'b101:  dec_fs = in_instr[30] ? FS_SRA : FS_SRL;
          3'b110:  dec_fs = FS_OR;
          default: dec_fs = FS_AND;
        endcase
        // Only funct7 0000000 and 0100000 exist, and the alternate form is
        // only meaningful for SUB and SRA.
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          dec_illegal = 1'b1;
        end
        if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101) begin
          dec_illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        dec_a  = in_rs1_data;
        dec_b  = i_imm;
        dec_we = 1'b1;
        case (funct3)
          3'b000:  dec_fs = FS_ADD;
          3'b001: begin
            dec_fs = FS_SLL;
            dec_b  = sh_imm;
          end
          3'b010:  dec_fs = FS_SLT;
          3'b011:  dec_fs = FS_SLTU;
          3'b100:  dec_fs = FS_XOR;
          3'b101: begin
            dec_fs = in_instr[30] ? FS_SRA : FS_SRL;
            dec_b  = sh_imm;
          end
          3'b110:  dec_fs = FS_OR;
          default: dec_fs = FS_AND;
        endcase
      end

      OPC_LUI: begin
        dec_b  = u_imm;
        dec_fs = FS_PASB;
        dec_we = 1'b1;
      end

      OPC_AUIPC: begin
        dec_a  = in_pc;
        dec_b  = u_imm;
        dec_we = 1'b1;
      end

      // The ALU produces the link address pc + 4.
      OPC_JAL, OPC_JALR: begin
        dec_a  = in_pc;
        dec_b  = 32'd4;
        dec_we = 1'b1;
      end

      OPC_BRANCH: begin
        dec_a      = in_rs1_data;
        dec_b      = in_rs2_data;
        dec_branch = 1'b1;
        dec_br_inv = funct3[0];
        case (funct3[2:1])
          2'b00:   dec_fs = FS_EQ;
          2'b10:   dec_fs = FS_SLT;
          2'b11:   dec_fs = FS_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        dec_a  = in_rs1_data;
        dec_b  = i_imm;
        dec_we = 1'b1;
      end

      OPC_STORE: begin
        dec_a = in_rs1_data;
        dec_b = s_imm;
      end

      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_a      = '0;
      dec_b      = '0;
      dec_fs     = FS_ADD;
      dec_we     = 1'b0;
      dec_branch = 1'b0;
      dec_br_inv = 1'b0;
    end

    // Writes to x0 are discarded at the source.
    if (rd == 5'd0) begin
      dec_we = 1'b0;
    end
  end

  logic slot_valid;
  logic slot_we;
  logic slot_branch;
  logic slot_illegal;
  logic load_slot;

  // The slot can take a new instruction when it is empty, when its current
  // occupant leaves this cycle, or when a flush is emptying it anyway.
  assign in_ready  = !slot_valid || out_ready || flush;
  assign load_slot = in_valid && in_ready && !flush;

  // Slot register. Flush beats everything except reset and drops the incoming
  // instruction. Payload only changes on a load, so a stalled slot is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid   <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_fs       <= FS_ADD;
      out_rd       <= '0;
      slot_we      <= 1'b0;
      slot_branch  <= 1'b0;
      out_br_inv   <= 1'b0;
      out_rs2_data <= '0;
      slot_illegal <= 1'b0;
    end else if (load_slot) begin
      slot_valid   <= 1'b1;
      alu_a        <= dec_a;
      alu_b        <= dec_b;
      alu_fs       <= dec_fs;
      out_rd       <= rd;
      slot_we      <= dec_we;
      slot_branch  <= dec_branch;
      out_br_inv   <= dec_br_inv;
      out_rs2_data <= in_rs2_data;
      slot_illegal <= dec_illegal;
    end else if (out_ready || flush) begin
      slot_valid <= 1'b0;
    end
  end

  // Side-effecting flags are qualified so an empty slot can never write back,
  // branch or trap.
  assign out_valid   = slot_valid;
  assign out_we      = slot_valid && slot_we;
  assign out_branch  = slot_valid && slot_branch;
  assign out_illegal = slot_valid && slot_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage: one linear stimulus sequence with
// hand-computed expected values for each instruction class, the stall and
// flush behaviour of the slot, and reset during a stall.

module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_fs;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_branch;
  logic        out_br_inv;
  logic [31:0] out_rs2_data;
  logic        out_illegal;

  int tests_run;
  int tests_failed;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_fs       (alu_fs),
    .out_rd       (out_rd),
    .out_we       (out_we),
    .out_branch   (out_branch),
    .out_br_inv   (out_br_inv),
    .out_rs2_data (out_rs2_data),
    .out_illegal  (out_illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic ordy,
                               input logic fl);
    in_valid    = v;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    out_ready   = ordy;
    flush       = fl;
    #1;
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  task automatic checkSlot(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] fs,
                           input logic [4:0] rd, input logic we, input logic br,
                           input logic inv, input logic ill);
    checkOutput({tag, ".valid"},   out_valid,   v);
    checkOutput({tag, ".a"},       alu_a,       a);
    checkOutput({tag, ".b"},       alu_b,       b);
    checkOutput({tag, ".fs"},      alu_fs,      fs);
    checkOutput({tag, ".rd"},      out_rd,      rd);
    checkOutput({tag, ".we"},      out_we,      we);
    checkOutput({tag, ".branch"},  out_branch,  br);
    checkOutput({tag, ".br_inv"},  out_br_inv,  inv);
    checkOutput({tag, ".illegal"}, out_illegal, ill);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    checkSlot("reset", 1'b0, 32'h0, 32'h0, 4'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("reset.in_ready", in_ready, 1'b1);

    // ADDI x5, x1, -1
    applyStimulus(1'b1, 32'hFFF08293, 32'h100, 32'h10, 32'h55, 1'b1, 1'b0);
    tick();
    checkSlot("addi", 1'b1, 32'h10, 32'hFFFFFFFF, 4'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    // SRAI x3, x3, 4
    applyStimulus(1'b1, 32'h4041D193, 32'h104, 32'h80000000, 32'h0, 1'b1, 1'b0);
    tick();
    checkSlot("srai", 1'b1, 32'h80000000, 32'h4, 4'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    // SUB x1, x2, x3
    applyStimulus(1'b1, 32'h403100B3, 32'h108, 32'h20, 32'h7, 1'b1, 1'b0);
    tick();
    checkSlot("sub", 1'b1, 32'h20, 32'h7, 4'd4, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // BGEU x1, x2, +8 (rd field holds offset bits = 8)
    applyStimulus(1'b1, 32'h0020F463, 32'h10C, 32'h5, 32'h6, 1'b1, 1'b0);
    tick();
    checkSlot("bgeu", 1'b1, 32'h5, 32'h6, 4'd13, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0);

    // LUI x7, 0x12345
    applyStimulus(1'b1, 32'h123453B7, 32'h110, 32'hAAAA, 32'hBBBB, 1'b1, 1'b0);
    tick();
    checkSlot("lui", 1'b1, 32'h0, 32'h12345000, 4'd9, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    // AUIPC x10, 1
    applyStimulus(1'b1, 32'h00001517, 32'h2000, 32'h1, 32'h2, 1'b1, 1'b0);
    tick();
    checkSlot("auipc", 1'b1, 32'h2000, 32'h1000, 4'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);

    // JAL x1, 0
    applyStimulus(1'b1, 32'h000000EF, 32'h3000, 32'h1, 32'h2, 1'b1, 1'b0);
    tick();
    checkSlot("jal", 1'b1, 32'h3000, 32'h4, 4'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // SW x2, 12(x1)
    applyStimulus(1'b1, 32'h0020A623, 32'h3004, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    checkSlot("sw", 1'b1, 32'h40, 32'hC, 4'd3, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw.rs2_data", out_rs2_data, 32'hDEADBEEF);

    // Opcode 0x7F with rd = 6
    applyStimulus(1'b1, 32'h0000037F, 32'h3008, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    checkSlot("opc7f", 1'b1, 32'h0, 32'h0, 4'd3, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);

    // OP with funct7 0x01 (MUL x1, x2, x3)
    applyStimulus(1'b1, 32'h023100B3, 32'h300C, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    checkSlot("funct7", 1'b1, 32'h0, 32'h0, 4'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // BRANCH with funct3 010
    applyStimulus(1'b1, 32'h0020A463, 32'h3010, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    checkSlot("brf3", 1'b1, 32'h0, 32'h0, 4'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);

    // ADDI x0, x1, 5: legal, but no writeback
    applyStimulus(1'b1, 32'h00508013, 32'h3014, 32'h33, 32'h0, 1'b1, 1'b0);
    tick();
    checkSlot("rd0", 1'b1, 32'h33, 32'h5, 4'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall: ADD x4, x1, x2 sits in the slot while SUB waits upstream
    applyStimulus(1'b1, 32'h00208233, 32'h400, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    checkSlot("add", 1'b1, 32'h11, 32'h22, 4'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h403100B3, 32'h404, 32'h99, 32'h1, 1'b0, 1'b0);
    checkOutput("stall0.in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkSlot("stall", 1'b1, 32'h11, 32'h22, 4'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("stall.in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release.in_ready", in_ready, 1'b1);
    tick();
    checkSlot("refill", 1'b1, 32'h99, 32'h1, 4'd4, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain.valid", out_valid, 1'b0);
    checkOutput("drain.we", out_we, 1'b0);

    // Flush with a full, stalled slot and an incoming LUI
    applyStimulus(1'b1, 32'h00208233, 32'h500, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    checkOutput("preflush.valid", out_valid, 1'b1);
    applyStimulus(1'b1, 32'h123453B7, 32'h504, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush.in_ready", in_ready, 1'b1);
    tick();
    checkOutput("flush.valid", out_valid, 1'b0);
    checkOutput("flush.we", out_we, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("postflush.valid", out_valid, 1'b0);

    // Reset while stalled discards the held instruction
    applyStimulus(1'b1, 32'h00208233, 32'h600, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("prerst.valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    checkSlot("midrst", 1'b0, 32'h0, 32'h0, 4'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("postrst.valid", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
